mi_nios_niosge_cpu_debug_action_sched: RTL

MI_NIOS_NIOSGE_CPU_DEBUG_ACTION_SCHED -- requirements
Module: mi_nios_niosge_cpu_debug_action_sched

---
 rtl/mi_nios_niosge_cpu_debug_action_sched.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mi_nios_niosge_cpu_debug_action_sched.sv
// Debug action scheduler: queues take_action strobes and issues them one at a time as commands.
// Latency: strobe to cmd_valid is 2 cycles from an empty, idle scheduler.
// Backpressure: a command holds until cmd_ready; a strobe into a full queue is dropped and sets overflow.
//
// Ports:
//   clk, reset_n             - single clock, asynchronous active-low reset
//   jdo                      - debug-slave data word, captured with the winning strobe
//   take_action_*            - one-cycle action strobes, types 0..5 in priority order
//   monitor_ready            - OCI monitor completion (level), ends WAIT_MON for types 0/1
//   cmd_ready                - downstream accepts the presented command
//   err_clear                - clears the sticky overflow / timeout_err flags
//   cmd_valid/type/data      - presented command
//   busy                     - scheduler active or queue non-empty
//   overflow, timeout_err    - sticky error flags
//   cmd_count                - handshake counter, live only when MI_NIOS_DEBUG_SCHED_STATS_EN is defined
module mi_nios_niosge_cpu_debug_action_sched #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_action_break_a,
  input  logic        take_action_break_b,
  input  logic        take_action_break_c,
  input  logic        take_action_tracectrl,
  input  logic        monitor_ready,
  input  logic        cmd_ready,
  input  logic        err_clear,
  output logic        cmd_valid,
  output logic [2:0]  cmd_type,
  output logic [37:0] cmd_data,
  output logic        busy,
  output logic        overflow,
  output logic        timeout_err,
  output logic [15:0] cmd_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_MON = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [40:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wait_q, wait_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_type_q, cmd_type_d;
  logic [37:0]   cmd_data_q, cmd_data_d;
  logic          overflow_q, timeout_q;

  logic [5:0]    stb;
  logic [2:0]    push_type;
  logic          push_req, lost, full, pop, push_ok, drop, tmo_set, hs;
  logic [40:0]   head;

  assign stb = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

  // Scan from the lowest priority upward so the last hit is the highest-priority strobe.
  always_comb begin
    push_type = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (stb[i]) push_type = 3'(i);
    end
  end

  assign push_req = |stb;
  // More than one bit set means at least one strobe lost arbitration.
  assign lost     = (stb & (stb - 6'd1)) != 6'd0;
  assign full     = (count_q == DEPTH_C);
  assign pop      = (state_q == IDLE) && (count_q != '0);
  // A pop in the same cycle frees a slot, so a push into a full queue still fits.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;
  assign head     = mem_q[rd_ptr_q];
  assign hs       = cmd_valid_q && cmd_ready;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_data_d  = cmd_data_q;
    wait_d      = wait_q;
    tmo_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_valid_d = 1'b1;
          cmd_type_d  = head[40:38];
          cmd_data_d  = head[37:0];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          cmd_valid_d = 1'b0;
          // Memory-access commands wait for the monitor to finish before the next issue.
          if (cmd_type_q <= 3'd1) begin
            state_d = WAIT_MON;
            wait_d  = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_MON: begin
        // monitor_ready is checked first so a coincident ack beats the timeout.
        if (monitor_ready) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == TMO_LAST) begin
            tmo_set = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= 8'd0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= 3'd0;
      cmd_data_q  <= 38'd0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      // Set has priority over clear on both sticky flags.
      if (drop || lost)   overflow_q <= 1'b1;
      else if (err_clear) overflow_q <= 1'b0;
      if (tmo_set)        timeout_q  <= 1'b1;
      else if (err_clear) timeout_q  <= 1'b0;
    end
  end

  // Queue storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_type, jdo};
  end

`ifdef MI_NIOS_DEBUG_SCHED_STATS_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'h0000;
    end else if (hs && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
  assign cmd_count = cnt_q;
`else
  assign cmd_count = 16'h0000;
`endif

  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_data    = cmd_data_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule
